// File: rtl/reg_file_dumper_if.sv
// Control, register-file read and stream-out signals of the register file dumper.
// master: the dumper itself; slave: the controller/consumer/register-file side.
interface reg_file_dumper_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              START;
  logic [ADDR_W-1:0] START_ADDR;
  logic [ADDR_W-1:0] END_ADDR;
  logic              ABORT;
  logic [ADDR_W-1:0] RF_ADDRESS;
  logic [DATA_W-1:0] RF_DATA;
  logic [DATA_W-1:0] OUT_DATA;
  logic [ADDR_W-1:0] OUT_INDEX;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_LAST;
  logic              OUT_CSUM;
  logic              BUSY;
  logic              DONE;

  modport master (
    input  START, START_ADDR, END_ADDR, ABORT, RF_DATA, OUT_READY,
    output RF_ADDRESS, OUT_DATA, OUT_INDEX, OUT_VALID, OUT_LAST, OUT_CSUM, BUSY, DONE
  );

  modport slave (
    output START, START_ADDR, END_ADDR, ABORT, RF_DATA, OUT_READY,
    input  RF_ADDRESS, OUT_DATA, OUT_INDEX, OUT_VALID, OUT_LAST, OUT_CSUM, BUSY, DONE
  );
endinterface

// File: rtl/reg_file_dumper.sv
// Walks a register-file address range through one read port and streams each word out.
// Define REG_FILE_DUMPER_CHECKSUM_EN to append an XOR checksum beat after the data beats.
module reg_file_dumper #(
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic               CLK,
  input logic               RESET,
  reg_file_dumper_if.master dump_io
);
  typedef enum logic [1:0] {StIdle, StSettle, StSend, StFin} state_e;

  localparam logic [3:0]      SettleLoad = 4'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W:0] RemOne     = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [3:0]        settle_q, settle_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] span;
  logic              last_reg;

`ifdef REG_FILE_DUMPER_CHECKSUM_EN
  logic              out_csum_q, out_csum_d;
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  assign span     = dump_io.END_ADDR - dump_io.START_ADDR;
  assign last_reg = (remaining_q == RemOne);

  always_comb begin
    state_d     = state_q;
    rf_addr_d   = rf_addr_q;
    remaining_d = remaining_q;
    settle_d    = settle_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
    out_csum_d  = out_csum_q;
    acc_d       = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (dump_io.START && !dump_io.ABORT) begin
          rf_addr_d   = dump_io.START_ADDR;
          remaining_d = {1'b0, span} + RemOne;
          settle_d    = SettleLoad;
          state_d     = StSettle;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
          acc_d       = '0;
`endif
        end
      end
      StSettle: begin
        if (settle_q == 4'd0) begin
          out_data_d  = dump_io.RF_DATA;
          out_index_d = rf_addr_q;
          out_valid_d = 1'b1;
          state_d     = StSend;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
          out_last_d  = 1'b0;
          out_csum_d  = 1'b0;
`else
          out_last_d  = last_reg;
`endif
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StSend: begin
        if (out_valid_q && dump_io.OUT_READY) begin
          out_valid_d = 1'b0;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
          if (out_csum_q) begin
            out_csum_d = 1'b0;
            state_d    = StFin;
          end else begin
            acc_d = acc_q ^ out_data_q;
            if (!last_reg) begin
              rf_addr_d   = rf_addr_q + 1'b1;
              remaining_d = remaining_q - RemOne;
              settle_d    = SettleLoad;
              state_d     = StSettle;
            end else begin
              // Checksum beat follows the last data beat directly, no settle needed.
              out_data_d  = acc_q ^ out_data_q;
              out_index_d = '0;
              out_csum_d  = 1'b1;
              out_last_d  = 1'b1;
              out_valid_d = 1'b1;
            end
          end
`else
          if (!last_reg) begin
            rf_addr_d   = rf_addr_q + 1'b1;
            remaining_d = remaining_q - RemOne;
            settle_d    = SettleLoad;
            state_d     = StSettle;
          end else begin
            state_d = StFin;
          end
`endif
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides any handshake acceptance in the same cycle.
    if (dump_io.ABORT && state_q != StIdle) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
      out_csum_d  = 1'b0;
      acc_d       = '0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      rf_addr_q   <= '0;
      remaining_q <= '0;
      settle_q    <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
      out_csum_q  <= 1'b0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rf_addr_q   <= rf_addr_d;
      remaining_q <= remaining_d;
      settle_q    <= settle_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
      out_csum_q  <= out_csum_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign dump_io.RF_ADDRESS = rf_addr_q;
  assign dump_io.OUT_DATA   = out_data_q;
  assign dump_io.OUT_INDEX  = out_index_q;
  assign dump_io.OUT_VALID  = out_valid_q;
  assign dump_io.OUT_LAST   = out_last_q;
  assign dump_io.BUSY       = (state_q != StIdle);
  assign dump_io.DONE       = (state_q == StFin);
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
  assign dump_io.OUT_CSUM   = out_csum_q;
`else
  assign dump_io.OUT_CSUM   = 1'b0;
`endif
endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed self-checking bench for reg_file_dumper with a behavioural 32x32 register file.
module tb_reg_file_dumper;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
  localparam bit LastOnData = 1'b0;
`else
  localparam bit LastOnData = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_dumper_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_file_dumper #(.ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(1)) dut (
    .CLK    (clk),
    .RESET  (rst_n),
    .dump_io(bus)
  );

  logic [DW-1:0] rf [32];
  assign bus.RF_DATA = rf[bus.RF_ADDRESS];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] rf_init(input int i);
    case (i)
      0:       rf_init = 32'h0;
      1:       rf_init = 32'h11;
      2:       rf_init = 32'h22;
      3:       rf_init = 32'h33;
      default: rf_init = 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  task automatic start_dump(input logic [4:0] sa, input logic [4:0] ea);
    @(negedge clk);
    bus.START = 1'b1; bus.START_ADDR = sa; bus.END_ADDR = ea;
    @(negedge clk);
    bus.START = 1'b0; bus.START_ADDR = ~sa; bus.END_ADDR = ~ea;
  endtask

  // Waits (bounded) at negedges for OUT_VALID and samples the beat; does not advance past it.
  task automatic get_beat(output bit ok, output int cyc, output logic [4:0] idx,
                          output logic [31:0] d, output bit last, output bit cs);
    cyc = 0;
    while (bus.OUT_VALID !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    ok = (bus.OUT_VALID === 1'b1);
    idx = bus.OUT_INDEX; d = bus.OUT_DATA; last = bus.OUT_LAST; cs = bus.OUT_CSUM;
  endtask

  task automatic test_reset();
    bit ok; int cyc; logic [4:0] idx; logic [31:0] d; bit last, cs;
    #1;
    n_checks++;
    if ({bus.RF_ADDRESS, bus.OUT_DATA, bus.OUT_INDEX, bus.OUT_VALID, bus.OUT_LAST,
         bus.OUT_CSUM, bus.BUSY, bus.DONE} !== '0) begin
      n_fail++; $display("FAIL reset_init: outputs got %h want 0", {bus.RF_ADDRESS, bus.OUT_DATA});
    end
    @(negedge clk); rst_n = 1'b1;
    bus.OUT_READY = 1'b0;
    start_dump(5'd1, 5'd3);
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || idx !== 5'd1) begin
      n_fail++; $display("FAIL reset_predump: ok=%0d idx got %0d want 1", ok, idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.RF_ADDRESS, bus.OUT_DATA, bus.OUT_INDEX, bus.OUT_VALID, bus.OUT_LAST,
         bus.OUT_CSUM} !== '0) begin
      n_fail++; $display("FAIL reset_middump: data got %h valid %b want 0", bus.OUT_DATA,
                         bus.OUT_VALID);
    end
    n_checks++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: busy %b done %b want 0 0", bus.BUSY, bus.DONE);
    end
    @(negedge clk); rst_n = 1'b1; bus.OUT_READY = 1'b1;
    start_dump(5'd2, 5'd2);
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || idx !== 5'd2 || d !== 32'h22 || last !== LastOnData) begin
      n_fail++; $display("FAIL reset_restart: idx %0d data %h last %b want 2 22 %b", idx, d,
                         last, LastOnData);
    end
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || cyc != 0 || d !== 32'h22 || cs !== 1'b1 || last !== 1'b1) begin
      n_fail++; $display("FAIL reset_csum: data %h csum %b want 22 1", d, cs);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1) begin
      n_fail++; $display("FAIL reset_done: got %b want 1", bus.DONE);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int cyc; logic [4:0] idx; logic [31:0] d; bit last, cs;
    bus.OUT_READY = 1'b1;
    start_dump(5'd1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      get_beat(ok, cyc, idx, d, last, cs);
      n_checks++;
      if (!ok || cyc != 1) begin
        n_fail++; $display("FAIL basic_latency[%0d]: ok=%0d cycles got %0d want 1", i, ok, cyc);
      end
      n_checks++;
      if (idx !== 5'(i + 1) || d !== rf_init(i + 1) || cs !== 1'b0) begin
        n_fail++; $display("FAIL basic_beat[%0d]: idx %0d data %h want %0d %h", i, idx, d,
                           i + 1, rf_init(i + 1));
      end
      n_checks++;
      if (last !== (LastOnData && i == 2)) begin
        n_fail++; $display("FAIL basic_last[%0d]: got %b want %b", i, last,
                           LastOnData && i == 2);
      end
    end
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || cyc != 0 || idx !== 5'd0 || d !== 32'h0 || cs !== 1'b1 || last !== 1'b1) begin
      n_fail++; $display("FAIL basic_csum: data %h csum %b last %b want 0 1 1", d, cs, last);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b1) begin
      n_fail++; $display("FAIL basic_done: done %b busy %b want 1 1", bus.DONE, bus.BUSY);
    end
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: done %b busy %b want 0 0", bus.DONE, bus.BUSY);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int cyc; logic [4:0] idx; logic [31:0] d; bit last, cs;
    bit stable;
    bus.OUT_READY = 1'b1;
    start_dump(5'd1, 5'd3);
    get_beat(ok, cyc, idx, d, last, cs);
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
    bus.OUT_READY = 1'b0;
    n_checks++;
    if (!ok || idx !== 5'd2 || d !== 32'h22) begin
      n_fail++; $display("FAIL bp_first: idx %0d data %h want 2 22", idx, d);
    end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // A START while busy must be ignored.
      bus.START = (i == 1); bus.START_ADDR = 5'd10; bus.END_ADDR = 5'd12;
      @(negedge clk);
      if (bus.OUT_VALID !== 1'b1 || bus.OUT_INDEX !== 5'd2 || bus.OUT_DATA !== 32'h22 ||
          bus.OUT_LAST !== 1'b0)
        stable = 1'b0;
    end
    bus.START = 1'b0;
    n_checks++;
    if (!stable) begin
      n_fail++; $display("FAIL bp_hold: stable got 0 want 1 (idx %0d data %h)", bus.OUT_INDEX,
                         bus.OUT_DATA);
    end
    bus.OUT_READY = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL bp_accept: valid got %b want 0", bus.OUT_VALID);
    end
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || cyc != 1 || idx !== 5'd3 || d !== 32'h33 || last !== LastOnData) begin
      n_fail++; $display("FAIL bp_third: idx %0d data %h cyc %0d want 3 33 1", idx, d, cyc);
    end
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
`endif
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1) begin
      n_fail++; $display("FAIL bp_done: got %b want 1", bus.DONE);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok; int cyc; logic [4:0] idx; logic [31:0] d; bit last, cs;
    logic [4:0] sa_tab [2];
    logic [4:0] ea_tab [2];
    int n_tab [2];
    logic [31:0] x;
    sa_tab[0] = 5'd30; ea_tab[0] = 5'd1; n_tab[0] = 4;
    sa_tab[1] = 5'd5;  ea_tab[1] = 5'd4; n_tab[1] = 32;
    bus.OUT_READY = 1'b1;
    for (int t = 0; t < 2; t++) begin
      start_dump(sa_tab[t], ea_tab[t]);
      x = '0;
      for (int i = 0; i < n_tab[t]; i++) begin
        if (i > 0) @(negedge clk);
        get_beat(ok, cyc, idx, d, last, cs);
        n_checks++;
        if (!ok || idx !== 5'(sa_tab[t] + 5'(i)) || d !== rf_init(int'(5'(sa_tab[t] + 5'(i)))) ||
            last !== (LastOnData && i == n_tab[t] - 1)) begin
          n_fail++; $display("FAIL wrap%0d[%0d]: idx %0d data %h last %b want %0d", t, i, idx,
                             d, last, 5'(sa_tab[t] + 5'(i)));
        end
        x = x ^ d;
      end
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
      @(negedge clk);
      get_beat(ok, cyc, idx, d, last, cs);
      n_checks++;
      if (!ok || d !== x || cs !== 1'b1 || last !== 1'b1 || idx !== 5'd0) begin
        n_fail++; $display("FAIL wrap%0d_csum: got %h want %h", t, d, x);
      end
`endif
      @(negedge clk);
      n_checks++;
      if (bus.DONE !== 1'b1) begin
        n_fail++; $display("FAIL wrap%0d_done: got %b want 1", t, bus.DONE);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    bit ok; int cyc; logic [4:0] idx; logic [31:0] d; bit last, cs;
    bit seen_done;
    bus.OUT_READY = 1'b1;
    start_dump(5'd4, 5'd7);
    get_beat(ok, cyc, idx, d, last, cs);
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
    bus.ABORT = 1'b1;
    @(negedge clk);
    bus.ABORT = 1'b0;
    n_checks++;
    if (bus.OUT_VALID !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 ||
        bus.OUT_LAST !== 1'b0) begin
      n_fail++; $display("FAIL abort_stop: valid %b busy %b done %b want 0 0 0", bus.OUT_VALID,
                         bus.BUSY, bus.DONE);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.DONE !== 1'b0 || bus.OUT_VALID !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++; $display("FAIL abort_quiet: activity got 1 want 0");
    end
    bus.START = 1'b1; bus.ABORT = 1'b1; bus.START_ADDR = 5'd4; bus.END_ADDR = 5'd7;
    @(negedge clk);
    bus.START = 1'b0; bus.ABORT = 1'b0;
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_idle: busy got %b want 0", bus.BUSY);
    end
    start_dump(5'd4, 5'd7);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      get_beat(ok, cyc, idx, d, last, cs);
      n_checks++;
      if (!ok || idx !== 5'(4 + i) || d !== rf_init(4 + i) ||
          last !== (LastOnData && i == 3)) begin
        n_fail++; $display("FAIL abort_redump[%0d]: idx %0d data %h want %0d %h", i, idx, d,
                           4 + i, rf_init(4 + i));
      end
    end
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || d !== 32'h0000_0000 || cs !== 1'b1) begin
      n_fail++; $display("FAIL abort_csum: got %h want 00000000", d);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1) begin
      n_fail++; $display("FAIL abort_done: got %b want 1", bus.DONE);
    end
    @(negedge clk);
  endtask

`ifdef REG_FILE_DUMPER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok; int cyc; logic [4:0] idx; logic [31:0] d; bit last, cs;
    rf[1] = 32'hF0F0_0000; rf[2] = 32'h0F0F_1234;
    bus.OUT_READY = 1'b1;
    start_dump(5'd1, 5'd2);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      get_beat(ok, cyc, idx, d, last, cs);
      n_checks++;
      if (!ok || idx !== 5'(i + 1) || last !== 1'b0 || cs !== 1'b0) begin
        n_fail++; $display("FAIL csum_data[%0d]: idx %0d last %b csum %b want %0d 0 0", i, idx,
                           last, cs, i + 1);
      end
    end
    @(negedge clk);
    get_beat(ok, cyc, idx, d, last, cs);
    n_checks++;
    if (!ok || d !== 32'hFFFF_1234 || idx !== 5'd0 || cs !== 1'b1 || last !== 1'b1) begin
      n_fail++; $display("FAIL csum_beat: data %h csum %b last %b want FFFF1234 1 1", d, cs,
                         last);
    end
    @(negedge clk);
    n_checks++;
    if (bus.DONE !== 1'b1) begin
      n_fail++; $display("FAIL csum_done: got %b want 1", bus.DONE);
    end
    @(negedge clk);
    rf[1] = rf_init(1); rf[2] = rf_init(2);
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = rf_init(i);
    bus.START = 1'b0; bus.START_ADDR = '0; bus.END_ADDR = '0;
    bus.ABORT = 1'b0; bus.OUT_READY = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
`ifdef REG_FILE_DUMPER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
